baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed UART clock divider.
- Generates a runtime-programmable oversample tick, a mid-bit sample strobe, a bit-rate tick and a 50% bit-rate square wave from the system clock.
- Sits between the system clock and the UART TX/RX engines. It replaces the single fixed 9.6 kHz output with selectable baud, oversampling and RX phase resync.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, reset-time baud rate.
- OVERSAMPLE, 16, oversample ticks per bit; even, >=2.
- DIV_WIDTH, 16, width of the divisor register.
- DEFAULT_DIV (localparam) = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), which is 651 at the defaults. Elaboration fails if the result is 0 or does not fit DIV_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  count enable; when low, all counters hold.
- div_load  in  1  load div_value into the divisor register.
- div_value  in  DIV_WIDTH  new divisor, in clk cycles per oversample tick.
- resync  in  1  restart bit phase (RX start-bit edge).
- os_tick  out  1  1-cycle pulse every div_reg enabled cycles.
- mid_tick  out  1  1-cycle pulse at the oversample mid-bit point.
- bit_tick  out  1  1-cycle pulse once per bit period.
- clkdiv  out  1  square wave at the bit rate, 50% duty.
- div_q  out  DIV_WIDTH  current divisor register value.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - div_reg = DEFAULT_DIV
  - os_cnt = 0, os_idx = 0
  - os_tick = mid_tick = bit_tick = 0
  - clkdiv = 0
- Registers:
  - os_cnt counts 0..div_reg-1.
  - os_idx counts 0..OVERSAMPLE-1.
  - All outputs are registered.
- Counting, on each cycle with en=1, no resync and no div_load:
  - If os_cnt == div_reg-1: os_cnt <= 0, os_tick <= 1, and os_idx advances (wraps OVERSAMPLE-1 -> 0). Otherwise os_cnt <= os_cnt+1 and os_tick <= 0.
  - mid_tick <= 1 when the os_tick event occurs with os_idx == OVERSAMPLE/2-1.
  - bit_tick <= 1 when the os_tick event occurs with os_idx == OVERSAMPLE-1.
  - clkdiv <= 1 on the mid_tick event; clkdiv <= 0 on the bit_tick event.
- Timing, with cycle 0 = first en=1 cycle after rst deasserts:
  - os_tick is high in cycles k*div_reg, k >= 1.
  - mid_tick is high in cycles (OVERSAMPLE/2)*div_reg + n*OVERSAMPLE*div_reg.
  - bit_tick is high in cycles n*OVERSAMPLE*div_reg, n >= 1.
  - clkdiv period = OVERSAMPLE*div_reg cycles.
- en=0: os_cnt, os_idx and clkdiv hold; os_tick, mid_tick and bit_tick are 0. Counting resumes from the held values.
- div_load=1, regardless of en:
  - div_reg <= max(div_value, 1); a value of 0 is clamped to 1.
  - os_cnt and os_idx are cleared to 0; all ticks are 0 that cycle; clkdiv <= 0.
  - The new divisor applies from the next cycle.
  - div_reg == 1 gives an os_tick every enabled cycle.
- resync=1, regardless of en: os_cnt, os_idx and clkdiv are cleared; ticks are 0 that cycle; div_reg is unchanged.
- resync and div_load in the same cycle: both apply — load plus clear.
- rst overrides div_load, resync and en. Reset mid-count restores DEFAULT_DIV and phase 0 on the next edge.
- No tick is ever emitted in the same cycle as rst, div_load or resync.
- div_q = div_reg, continuously.

Test Plan:
- Reset: rst=1 for 3 cycles -> all ticks 0, clkdiv=0, div_q=651. Release with en=1 -> first os_tick at cycle 651, first bit_tick at cycle 10416, clkdiv rises at cycle 5208.
- Load divisor: div_load with div_value=4, OVERSAMPLE=16 -> os_tick every 4 cycles, mid_tick at cycle 32, bit_tick at cycles 64 and 128, clkdiv high on cycles 32..63.
- Clamp: div_load with div_value=0 -> div_q=1, os_tick high every cycle, bit_tick every 16 cycles.
- Enable gating (div=4): drop en for 10 cycles at cycle 30 -> no ticks during the gap; mid_tick slips to cycle 42; clkdiv held throughout the gap.
- Resync mid-bit (div=4): resync at cycle 50 -> clkdiv=0 next cycle; next mid_tick 32 cycles later and next bit_tick 64 cycles later, both counted from the resync cycle.
- Simultaneous events: resync and div_load (value 8) in the same cycle -> div_q=8, phase cleared, first os_tick 8 cycles later. rst asserted together with div_load -> div_q=651.

Source files
------------

// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
//   Programmable UART timing generator. Divides clk by a runtime divisor to
//   produce an oversample tick, then divides that by OVERSAMPLE to produce a
//   mid-bit sample strobe, a bit-rate tick and a 50% duty bit-rate square wave.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   count enable; counters and clkdiv hold while low
//   div_load   in   load div_value (0 clamps to 1), clears bit phase
//   div_value  in   new divisor, clk cycles per oversample tick
//   resync     in   clear bit phase (RX start-bit edge)
//   os_tick    out  1-cycle pulse every div_q enabled cycles
//   mid_tick   out  1-cycle pulse at the mid-bit oversample point
//   bit_tick   out  1-cycle pulse once per bit period
//   clkdiv     out  bit-rate square wave, high for the second half-bit
//   div_q      out  current divisor register
// ----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 resync,
    output logic                 os_tick,
    output logic                 mid_tick,
    output logic                 bit_tick,
    output logic                 clkdiv,
    output logic [DIV_WIDTH-1:0] div_q
);

    localparam longint DEFAULT_DIV =
        (longint'(CLK_FREQ) + longint'(BAUD) * OVERSAMPLE / 2) /
        (longint'(BAUD) * OVERSAMPLE);
    localparam int IDX_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]     IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

    generate
        if (DEFAULT_DIV == 0 || DEFAULT_DIV >= (longint'(1) << DIV_WIDTH)) begin : g_bad_div
            $error("baud_tick_gen: DEFAULT_DIV is 0 or does not fit DIV_WIDTH");
        end
        if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("baud_tick_gen: OVERSAMPLE must be even and >= 2");
        end
    endgenerate

    logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0] os_cnt_q,  os_cnt_d;
    logic [IDX_W-1:0]     os_idx_q,  os_idx_d;
    logic                 os_tick_q, os_tick_d;
    logic                 mid_tick_q, mid_tick_d;
    logic                 bit_tick_q, bit_tick_d;
    logic                 clkdiv_q,  clkdiv_d;

    always_comb begin
        div_reg_d  = div_reg_q;
        os_cnt_d   = os_cnt_q;
        os_idx_d   = os_idx_q;
        clkdiv_d   = clkdiv_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;

        if (div_load || resync) begin
            // Phase restart; a load also swaps the divisor, which takes
            // effect from the first counting cycle after this one.
            os_cnt_d = '0;
            os_idx_d = '0;
            clkdiv_d = 1'b0;
            if (div_load)
                div_reg_d = (div_value == '0) ? DIV_ONE : div_value;
        end else if (en) begin
            if (os_cnt_q == div_reg_q - DIV_ONE) begin
                os_cnt_d  = '0;
                os_tick_d = 1'b1;
                os_idx_d  = (os_idx_q == IDX_LAST) ? '0 : os_idx_q + IDX_W'(1);
                if (os_idx_q == IDX_MID) begin
                    mid_tick_d = 1'b1;
                    clkdiv_d   = 1'b1;
                end
                if (os_idx_q == IDX_LAST) begin
                    bit_tick_d = 1'b1;
                    clkdiv_d   = 1'b0;
                end
            end else begin
                os_cnt_d = os_cnt_q + DIV_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg_q  <= DIV_RST;
            os_cnt_q   <= '0;
            os_idx_q   <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            clkdiv_q   <= 1'b0;
        end else begin
            div_reg_q  <= div_reg_d;
            os_cnt_q   <= os_cnt_d;
            os_idx_q   <= os_idx_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            clkdiv_q   <= clkdiv_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;
    assign clkdiv   = clkdiv_q;
    assign div_q    = div_reg_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// ----------------------------------------------------------------------------
// tb_baud_tick_gen
//   Directed scenarios followed by random en/div_load/resync/rst traffic.
//   The reference model tracks only the number of enabled cycles since the
//   last phase clear and derives every output from it arithmetically.
// ----------------------------------------------------------------------------
module tb_baud_tick_gen;

    localparam int OS      = 16;
    localparam int DW      = 16;
    localparam int DEF_DIV = 651;

    logic          clk = 1'b0;
    logic          rst, en, div_load, resync;
    logic [DW-1:0] div_value;
    logic          os_tick, mid_tick, bit_tick, clkdiv;
    logic [DW-1:0] div_q;

    baud_tick_gen #(
        .CLK_FREQ(100000000), .BAUD(9600), .OVERSAMPLE(OS), .DIV_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .div_load(div_load),
        .div_value(div_value), .resync(resync),
        .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
        .clkdiv(clkdiv), .div_q(div_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          os;
        logic          mid;
        logic          bt;
        logic          ck;
        logic [DW-1:0] dv;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;
    bit   stim_done = 0;

    // Model state: divisor, enabled cycles since last clear, and whether the
    // cycle just finished was a plain counting cycle (ticks only follow those).
    longint m_div     = DEF_DIV;
    longint m_phase   = 0;
    bit     m_counted = 0;

    function automatic exp_t model_out();
        exp_t   e;
        longint bitlen = OS * m_div;
        longint pos    = m_phase % bitlen;
        e.os  = m_counted && (m_phase % m_div == 0);
        e.mid = m_counted && (pos == (OS / 2) * m_div);
        e.bt  = m_counted && (pos == 0);
        e.ck  = (pos >= (OS / 2) * m_div);
        e.dv  = DW'(m_div);
        e.cyc = cyc_no;
        return e;
    endfunction

    // Apply inputs for one cycle, then at the edge advance the model and
    // queue the outputs the DUT should show after that edge.
    task automatic cyc(input bit r, input bit e, input bit ld,
                       input logic [DW-1:0] v, input bit rs);
        rst = r; en = e; div_load = ld; div_value = v; resync = rs;
        @(posedge clk);
        if (r) begin
            m_div = DEF_DIV; m_phase = 0; m_counted = 0;
        end else if (ld || rs) begin
            if (ld) m_div = (v == 0) ? 1 : longint'(v);
            m_phase = 0; m_counted = 0;
        end else if (e) begin
            m_phase++; m_counted = 1;
        end else begin
            m_counted = 0;
        end
        cyc_no++;
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) cyc(0, e, 0, '0, 0);
    endtask

    // Monitor: outputs are presented every cycle, so pop one entry per
    // falling edge whenever the stimulus side has queued one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (os_tick === e.os && mid_tick === e.mid && bit_tick === e.bt &&
                    clkdiv === e.ck && div_q === e.dv)
                    n_pass++;
                else
                    $display("FAIL outputs cyc=%0d got os=%b mid=%b bit=%b clkdiv=%b div_q=%0d want os=%b mid=%b bit=%b clkdiv=%b div_q=%0d",
                             e.cyc, os_tick, mid_tick, bit_tick, clkdiv, div_q,
                             e.os, e.mid, e.bt, e.ck, e.dv);
            end
        end
    end

    initial begin
        rst = 1; en = 0; div_load = 0; div_value = '0; resync = 0;

        // Reset held for 3 cycles, then default divisor runs past first bit.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0, 0);
        run(10500, 1);

        // Small divisor: ticks every 4, mid at 32, bits at 64/128.
        cyc(0, 1, 1, DW'(4), 0);
        run(140, 1);

        // Divisor 0 clamps to 1.
        cyc(0, 1, 1, DW'(0), 0);
        run(40, 1);

        // Enable gap of 10 cycles starting at cycle 30 (div=4).
        cyc(0, 1, 1, DW'(4), 0);
        run(30, 1);
        run(10, 0);
        run(40, 1);

        // Resync mid-bit at cycle 50 (div=4).
        cyc(0, 1, 1, DW'(4), 0);
        run(50, 1);
        cyc(0, 1, 0, '0, 1);
        run(140, 1);

        // load is honoured even with en low.
        cyc(0, 0, 1, DW'(3), 0);
        run(60, 1);

        // Simultaneous resync + load, then rst + load.
        run(13, 1);
        cyc(0, 1, 1, DW'(8), 1);
        run(20, 1);
        cyc(1, 1, 1, DW'(5), 1);
        run(700, 1);

        // Random traffic with small divisors.
        cyc(0, 1, 1, DW'(2), 0);
        for (int i = 0; i < 8000; i++) begin
            int  r  = $urandom_range(0, 999);
            bit  e  = ($urandom_range(0, 9) != 0);
            if (r < 2)
                cyc(1, e, $urandom_range(0, 1), DW'($urandom_range(0, 6)), $urandom_range(0, 1));
            else if (r < 10)
                cyc(0, e, 1, DW'($urandom_range(0, 6)), $urandom_range(0, 1));
            else if (r < 18)
                cyc(0, e, 0, '0, 1);
            else
                cyc(0, e, 0, '0, 0);
            // Reset restores 651; reload a short divisor so bits keep coming.
            if (m_div > 100) cyc(0, 1, 1, DW'($urandom_range(1, 5)), 0);
        end

        stim_done = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
